// File: rtl/regfile_pkg.sv
// Shared sizing and bus type for the ARM register file write port and read muxes.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  // Bit-major layout: reg_bus_t[b][r] is bit b of register r.
  typedef logic [DATA_W-1:0][NUM_REGS-1:0] reg_bus_t;

endpackage

// File: rtl/decoder_5_32.sv
// One-hot 5:32 write-enable decoder: a 2:4 stage selecting one of four 3:8 stages.
module decoder_5_32
  import regfile_pkg::*;
(
  input  logic              enable,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       out
);

  logic [3:0] grp;

  always_comb begin
    grp = 4'b0000;
    if (enable) grp[addr[4:3]] = 1'b1;
  end

  always_comb begin
    out = '0;
    for (int g = 0; g < 4; g++) begin
      out[g*8 +: 8] = grp[g] ? (8'b0000_0001 << addr[2:0]) : 8'b0000_0000;
    end
  end

endmodule

// File: rtl/register_64.sv
// One architectural register: DFFs with a hold/load mux, synchronously cleared.
module register_64
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = enable ? D : q_q;
    if (reset) q_d = '0;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/regfile_write_port.sv
// Write side and storage of the 32 x 64-bit register file; register 31 reads as zero.
module regfile_write_port
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  output reg_bus_t          regData,
  output logic [ADDR_W-1:0] lastWritten,
  output logic              writeValid
);

  logic [NUM_REGS-1:0] en;
  logic [DATA_W-1:0]   reg_q [NUM_REGS-1];
  logic                unused_zero_en;

  logic [ADDR_W-1:0]   last_q, last_d;
  logic                valid_q, valid_d;

  decoder_5_32 u_dec (
    .enable (RegWrite),
    .addr   (WriteRegister),
    .out    (en)
  );

  // XZR has no storage, so its decoded enable is intentionally dropped.
  assign unused_zero_en = en[ZERO_REG];

  for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_reg
    register_64 u_reg (
      .clk    (clk),
      .reset  (reset),
      .enable (en[r]),
      .D      (WriteData),
      .Q      (reg_q[r])
    );
  end

  always_comb begin
    regData = '0;
    for (int r = 0; r < NUM_REGS - 1; r++) begin
      for (int b = 0; b < DATA_W; b++) begin
        regData[b][r] = reg_q[r][b];
      end
    end
  end

  always_comb begin
    valid_d = RegWrite & ~reset;
    last_d  = last_q;
    if (reset)         last_d = ADDR_W'(ZERO_REG);
    else if (RegWrite) last_d = WriteRegister;
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    last_q  <= last_d;
  end

  assign writeValid  = valid_q;
  assign lastWritten = last_q;

endmodule

// File: tb/tb_regfile_write_port.sv
// Scoreboard bench for regfile_write_port: expected state queued per edge, compared after it.
module tb_regfile_write_port;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  reg_bus_t          regData;
  logic [ADDR_W-1:0] lastWritten;
  logic              writeValid;

  regfile_write_port dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .regData       (regData),
    .lastWritten   (lastWritten),
    .writeValid    (writeValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              vld;
    logic [ADDR_W-1:0] last;
    logic [DATA_W-1:0] regs [NUM_REGS];
  } exp_t;

  exp_t              sb_q [$];
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic [ADDR_W-1:0] m_last;
  logic              m_vld;
  int                total = 0;
  int                bad = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] reg_of(input int r);
    logic [DATA_W-1:0] v;
    for (int b = 0; b < DATA_W; b++) v[b] = regData[b][r];
    return v;
  endfunction

  task automatic step(input logic rst, input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset = rst; RegWrite = we; WriteRegister = addr; WriteData = data;
    #1;
    // Before the edge the target register must still show its old contents.
    chk($sformatf("pre_edge_r%0d", addr), reg_of(int'(addr)), m_regs[addr]);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_last = ADDR_W'(ZERO_REG);
      m_vld  = 1'b0;
    end else begin
      m_vld = we;
      if (we) begin
        m_last = addr;
        if (int'(addr) != ZERO_REG) m_regs[addr] = data;
      end
    end
    e.vld = m_vld; e.last = m_last;
    foreach (m_regs[i]) e.regs[i] = m_regs[i];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk("writeValid", 64'(writeValid), 64'(got.vld));
    chk("lastWritten", 64'(lastWritten), 64'(got.last));
    for (int r = 0; r < NUM_REGS; r++)
      chk($sformatf("reg%0d", r), reg_of(r), got.regs[r]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    m_last = ADDR_W'(ZERO_REG);
    m_vld = 1'b0;
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;

    step(1'b1, 1'b0, 5'd0, 64'h0);
    step(1'b1, 1'b0, 5'd0, 64'h0);

    step(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567);
    step(1'b0, 1'b0, 5'd5, 64'h0);

    step(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, 1'b0, 5'd7, 64'h1234);

    step(1'b0, 1'b1, 5'd3, 64'h1);
    step(1'b0, 1'b1, 5'd3, 64'h2);
    step(1'b0, 1'b1, 5'd30, 64'h8000_0000_0000_0000);
    step(1'b0, 1'b0, 5'd0, 64'h0);

    for (int i = 0; i < NUM_REGS - 1; i++)
      step(1'b0, 1'b1, ADDR_W'(i), 64'(i + 1));

    step(1'b1, 1'b1, 5'd10, 64'hAA);
    step(1'b0, 1'b1, 5'd10, 64'hAA);
    step(1'b0, 1'b1, 5'd0, 64'h5555_AAAA_5555_AAAA);

    for (int i = 0; i < 40; i++)
      step(1'b0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)),
           {$urandom, $urandom});

    step(1'b1, 1'b0, 5'd0, 64'h0);
    step(1'b0, 1'b1, 5'd29, 64'hCAFE_F00D_0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
